// File: rtl/cp0_reg.sv
// cp0_reg: MIPS CP0 register file (BadVAddr/Count/Compare/Status/Cause/EPC/PRId/Config); MTC0/MFC0 access, exception/ERET commit, timer interrupt
module cp0_reg #(
  parameter logic [31:0] PRID_VAL   = 32'h004C_0102,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] data_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] except_type_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] badvaddr_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  logic        tick;
  logic        noexc, eret, exc, adr;
  logic [4:0]  exc_code;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  always_comb begin
    noexc    = except_type_i == 32'h0;
    eret     = except_type_i == 32'he;
    adr      = except_type_i == 32'h4 || except_type_i == 32'h5;
    exc      = except_type_i == 32'h1 || adr || except_type_i == 32'h8 || except_type_i == 32'h9 ||
               except_type_i == 32'ha || except_type_i == 32'hc;
    exc_code = except_type_i == 32'h1 ? 5'h00 : except_type_i[4:0];
    wr_count   = we_i && noexc && waddr_i == 5'd9;
    wr_compare = we_i && noexc && waddr_i == 5'd11;
    wr_status  = we_i && noexc && waddr_i == 5'd12;
    wr_cause   = we_i && noexc && waddr_i == 5'd13;
    wr_epc     = we_i && noexc && waddr_i == 5'd14;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tick        <= 1'b0;
      count_o     <= '0;
      compare_o   <= '0;
      status_o    <= 32'h0040_0000;
      cause_o     <= '0;
      epc_o       <= '0;
      badvaddr_o  <= '0;
      timer_int_o <= 1'b0;
    end else begin
      tick    <= ~tick;
      count_o <= wr_count ? data_i : count_o + {31'b0, tick};
      if (compare_o != 32'h0 && count_o == compare_o) timer_int_o <= 1'b1;
      if (wr_compare) begin
        compare_o   <= data_i;
        timer_int_o <= 1'b0;
      end
      cause_o[15:10] <= int_i;
      cause_o[30]    <= timer_int_o;
      if (wr_status) status_o <= (status_o & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
      if (wr_cause) cause_o[9:8] <= data_i[9:8];
      if (wr_epc) epc_o <= data_i;
      // A nested exception (EXL already set) keeps the original return point.
      if (exc) begin
        if (!status_o[1]) begin
          epc_o       <= is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
          cause_o[31] <= is_in_delayslot_i;
        end
        status_o[1]  <= 1'b1;
        cause_o[6:2] <= exc_code;
        if (adr) badvaddr_o <= badvaddr_i;
      end else if (eret) status_o[1] <= 1'b0;
    end
  end
  assign prid_o   = PRID_VAL;
  assign config_o = CONFIG_VAL;
  always_comb
    data_o = raddr_i == 5'd8  ? badvaddr_o :
             raddr_i == 5'd9  ? count_o :
             raddr_i == 5'd11 ? compare_o :
             raddr_i == 5'd12 ? status_o :
             raddr_i == 5'd13 ? cause_o :
             raddr_i == 5'd14 ? epc_o :
             raddr_i == 5'd15 ? prid_o :
             raddr_i == 5'd16 ? config_o : 32'h0;
endmodule

// File: doc/cp0_reg.md
# cp0_reg

Coprocessor-0 register file for the MIPS pipeline. It holds the architectural CP0 state, which is BadVAddr, Count, Compare, Status, Cause, EPC, PRId and Config. It services MTC0/MFC0 accesses from the memory stage. It commits precise-exception and ERET state updates using the `except_type`, PC, delay-slot and bad-address information produced by the exception unit. It feeds `status_o`, `cause_o` and `epc_o` back to that unit.

## Interface
Parameters:
- `PRID_VAL`, default 32'h004C_0102: reset and constant value of PRId.
- `CONFIG_VAL`, default 32'h0000_8000: reset and constant value of Config.

Ports (the reset polarity and synchronicity below are decided: one clock, synchronous active-high reset):
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `we_i` in 1: MTC0 write enable.
- `waddr_i` in 5: CP0 register number to write.
- `raddr_i` in 5: CP0 register number to read (MFC0).
- `data_i` in 32: MTC0 write data.
- `int_i` in 6: external hardware interrupt lines.
- `except_type_i` in 32: EXC_TYPE_* code from the exception unit.
- `current_inst_addr_i` in 32: PC of the M-stage instruction (`pcM`).
- `is_in_delayslot_i` in 1: the M-stage instruction is in a branch delay slot.
- `badvaddr_i` in 32: faulting address (`badvaddrM`).
- `data_o` out 32: MFC0 read data.
- `count_o`, `compare_o`, `status_o`, `cause_o`, `epc_o`, `badvaddr_o`, `config_o`, `prid_o` out 32 each: current register values.
- `timer_int_o` out 1: Count/Compare match interrupt pending.

## Operation
- Register map:
  - BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14, PRId=15, Config=16.
  - Any other `raddr_i` reads 0. A write to any other address is ignored.
- Reset values:
  - Count 0, Compare 0, Cause 0, EPC 0, BadVAddr 0.
  - Status 32'h0040_0000 (BEV=1).
  - PRId = `PRID_VAL`, Config = `CONFIG_VAL`.
  - `timer_int_o` 0. Internal divide-by-two `tick` 0.
- Count:
  - `tick` toggles every cycle.
  - Count increments by 1 on cycles where `tick`==1, so it advances once per two clocks.
  - Count wraps 32'hFFFF_FFFF to 0.
- Timer:
  - When Compare != 0 and Count == Compare, `timer_int_o` is set to 1 next edge. It stays set until Compare is written.
  - An MTC0 to Compare clears `timer_int_o`.
- Cause interrupt bits, updated every cycle:
  - Cause[15:10] <= `int_i`.
  - Cause[30] (TI) <= `timer_int_o`.
- MTC0 writable fields (applied only when `except_type_i` == EXC_TYPE_NOEXC):
  - Count: all bits.
  - Compare: all bits.
  - Status: bits 15:8 (IM), 1 (EXL) and 0 (IE).
  - Cause: bits 9:8 (software IP).
  - EPC: all bits.
  - BadVAddr, PRId, Config: read-only.
  - An MTC0 write to Count overrides that cycle's increment.
- Exception commit, when `except_type_i` != EXC_TYPE_NOEXC:
  - The MTC0 write of that cycle is discarded entirely.
  - Codes written to Cause[6:2] (ExcCode): INT (32'h1) 0x00, ADEL (32'h4) 0x04, ADES (32'h5) 0x05, SYS (32'h8) 0x08, BP (32'h9) 0x09, RI (32'ha) 0x0a, OV (32'hc) 0x0c. NOEXC = 32'h0, ERET = 32'he.
  - For every type except ERET:
    - If Status.EXL==0: EPC <= `is_in_delayslot_i` ? PC−4 : PC, and Cause[31] (BD) <= `is_in_delayslot_i`.
    - If EXL is already 1, EPC and BD are unchanged.
    - Status.EXL <= 1 and Cause[6:2] <= ExcCode.
  - ADEL/ADES additionally load BadVAddr <= `badvaddr_i`.
  - ERET: Status.EXL <= 0. No other register changes.
  - An unknown nonzero code is treated as no-op except that the MTC0 write is still discarded.
- MFC0: `data_o` is a combinational mux of the registered values selected by `raddr_i`.

## Timing
- All register updates land at the rising edge following the cycle their inputs are presented.
- `data_o` and the `*_o` register outputs reflect state before that edge. Same-cycle MTC0→MFC0 to the same register returns the old value; the pipeline forwards.
- Compare match:
  - Detected on the registered Count/Compare, so `timer_int_o` rises one cycle after Count equals Compare.
  - Cause[30] follows one cycle after `timer_int_o`.
- Reset asserted mid-operation restores every reset value at the next edge, overriding all writes, exceptions and count increments in that cycle.

## Test plan
- Reset, then idle 10 cycles → Count reads 5; Status 32'h0040_0000; `timer_int_o`=0.
- MTC0 Compare=3, hold → `timer_int_o`=1 one cycle after Count reaches 3, Cause[30]=1 the next cycle; MTC0 Compare=100 → `timer_int_o`=0 next cycle.
- `except_type_i`=32'h4, PC=32'hBFC0_0100, delay slot=1, `badvaddr_i`=32'h1 → EPC=32'hBFC0_00FC, BD=1, ExcCode=0x04, EXL=1, BadVAddr=32'h1.
- With EXL=1, apply SYS at PC 32'h8000_0000 → ExcCode=0x08, EPC and BD unchanged; then ERET → EXL=0.
- Same cycle: MTC0 Status=32'h0000_FF01 plus OV → Status IM/IE unchanged, EXL=1, ExcCode=0x0c.
- MTC0 Count=32'hFFFF_FFFF → Count reads 0 after next increment tick; MTC0 to PRId ignored (reads `PRID_VAL`); MFC0 reg 20 → 0.
